ropuf_eval_ctrl: RTL and testbench

- Sequencer for the ring-oscillator PUF measurement datapath. Steps through N_PAIRS RO pairs.
- For each pair it clears the RO counters, opens a fixed counting window, waits for the counts to settle, then compares the two counts into one response bit.
- Assembles the N_PAIRS-bit response word that feeds the AES key path.
- Sits between the RO counter bank and the key register/ECC stage.

---
 rtl/ropuf_eval_ctrl.sv | 128 ++++++++++++
 tb/tb_ropuf_eval_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ropuf_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer: clears, windows, settles and
// compares each RO pair in turn, assembling the N_PAIRS-bit response word.
module ropuf_eval_ctrl #(
    parameter int N_PAIRS       = 128,
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int SEL_W         = $clog2(N_PAIRS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_W-1:0]               ro_cnt_a,
    input  logic [CNT_W-1:0]               ro_cnt_b,
    output logic [SEL_W-1:0]               ro_sel,
    output logic                           ro_en,
    output logic                           cnt_clr,
    output logic                           busy,
    output logic                           done,
    output logic [N_PAIRS-1:0]             key,
    output logic                           key_valid,
    output logic [$clog2(N_PAIRS+1)-1:0]   tie_cnt
);

    localparam int TIE_W = $clog2(N_PAIRS + 1);
    localparam int WIN_W = $clog2(WIN_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CMP    = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    logic [2:0]         r_state;
    logic [WIN_W-1:0]   r_win;
    logic [SET_W-1:0]   r_set;
    logic [SEL_W-1:0]   r_sel;
    logic [N_PAIRS-1:0] r_key;
    logic [TIE_W-1:0]   r_tie;
    logic               r_busy;
    logic               r_key_valid;

    logic w_a_gt_b;
    logic w_tie;
    logic w_last;

    // Raw unsigned compare; counter wrap is deliberately not detected.
    assign w_a_gt_b = (ro_cnt_a > ro_cnt_b);
    assign w_tie    = (ro_cnt_a == ro_cnt_b);
    assign w_last   = (r_sel == SEL_W'(N_PAIRS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_win       <= '0;
            r_set       <= '0;
            r_sel       <= '0;
            r_key       <= '0;
            r_tie       <= '0;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLR;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_key       <= '0;
                        r_tie       <= '0;
                        r_sel       <= '0;
                    end
                end
                S_CLR: begin
                    r_state <= S_RUN;
                    r_win   <= WIN_W'(WIN_CYCLES - 1);
                end
                S_RUN: begin
                    if (r_win == '0) begin
                        r_state <= S_SETTLE;
                        r_set   <= SET_W'(SETTLE_CYCLES - 1);
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_set == '0) begin
                        r_state <= S_CMP;
                    end else begin
                        r_set <= r_set - SET_W'(1);
                    end
                end
                S_CMP: begin
                    r_key[r_sel] <= w_a_gt_b;
                    if (w_tie) begin
                        r_tie <= r_tie + TIE_W'(1);
                    end
                    if (w_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_sel   <= r_sel + SEL_W'(1);
                        r_state <= S_CLR;
                    end
                end
                S_FIN: begin
                    r_key_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ro_en     = (r_state == S_RUN);
    assign cnt_clr   = (r_state == S_CLR);
    assign done      = (r_state == S_FIN);
    assign ro_sel    = r_sel;
    assign busy      = r_busy;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign tie_cnt   = r_tie;

endmodule

// File: tb/tb_ropuf_eval_ctrl.sv
// Scoreboard bench for ropuf_eval_ctrl: driver pushes expected responses,
// a negedge monitor pops and checks them when done pulses.
module tb_ropuf_eval_ctrl;

    localparam int NP  = 4;
    localparam int WIN = 8;
    localparam int SET = 2;
    localparam int LAT = NP * (WIN + SET + 2) + 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] ro_cnt_a;
    logic [15:0] ro_cnt_b;
    logic [1:0]  ro_sel;
    logic        ro_en;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic [3:0]  key;
    logic        key_valid;
    logic [2:0]  tie_cnt;

    logic [15:0] ta [NP];
    logic [15:0] tb [NP];

    typedef struct {
        logic [3:0] key;
        logic [2:0] tie;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    ropuf_eval_ctrl #(
        .N_PAIRS(NP),
        .CNT_W(16),
        .WIN_CYCLES(WIN),
        .SETTLE_CYCLES(SET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ro_cnt_a(ro_cnt_a),
        .ro_cnt_b(ro_cnt_b),
        .ro_sel(ro_sel),
        .ro_en(ro_en),
        .cnt_clr(cnt_clr),
        .busy(busy),
        .done(done),
        .key(key),
        .key_valid(key_valid),
        .tie_cnt(tie_cnt)
    );

    // Counter model: the selected pair's settled counts.
    assign ro_cnt_a = ta[ro_sel];
    assign ro_cnt_b = tb[ro_sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor
    int   clr_in_run;
    int   ro_len;
    logic sel_bad;
    logic [1:0] cur_sel;
    logic prev_clr;
    logic prev_en;
    logic pend_kv;

    initial begin
        exp_t e;
        clr_in_run = 0;
        ro_len     = 0;
        sel_bad    = 1'b0;
        cur_sel    = '0;
        prev_clr   = 1'b0;
        prev_en    = 1'b0;
        pend_kv    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                clr_in_run = 0;
                ro_len     = 0;
                sel_bad    = 1'b0;
                prev_clr   = 1'b0;
                prev_en    = 1'b0;
                pend_kv    = 1'b0;
            end else begin
                if (pend_kv) begin
                    chk("kv_after_done", {key_valid, busy}, 2'b10);
                    pend_kv = 1'b0;
                end
                if (cnt_clr) begin
                    if (prev_clr) chk("clr_width", 2, 1);
                    chk("sel_at_clr", ro_sel, clr_in_run);
                    cur_sel = ro_sel;
                    clr_in_run++;
                end
                if (ro_en) begin
                    ro_len++;
                    if (ro_sel != cur_sel) sel_bad = 1'b1;
                end else if (prev_en) begin
                    chk("ro_en_len", ro_len, WIN);
                    chk("sel_stable", sel_bad, 0);
                    ro_len  = 0;
                    sel_bad = 1'b0;
                end
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_cycle", cyc + 1, e.cyc);
                        chk("key", key, e.key);
                        chk("tie_cnt", tie_cnt, e.tie);
                        chk("clr_count", clr_in_run, NP);
                    end
                    clr_in_run = 0;
                    pend_kv    = 1'b1;
                end
                prev_clr = cnt_clr;
                prev_en  = ro_en;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic push(input logic [3:0] k, input logic [2:0] t,
                        input int c);
        exp_t e;
        e.key = k;
        e.tie = t;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic set_nominal();
        ta[0] = 16'd100;  tb[0] = 16'd90;
        ta[1] = 16'd50;   tb[1] = 16'd60;
        ta[2] = 16'd7;    tb[2] = 16'd7;
        ta[3] = 16'hFFFF; tb[3] = 16'd0;
    endtask

    // Driver
    initial begin
        int acc;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        start  = 1'b0;
        set_nominal();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs",
                {ro_sel, ro_en, cnt_clr, busy, done, key, key_valid, tie_cnt},
                '0);
        end
        reset = 1'b0;

        // Nominal run
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        push(4'b1001, 3'd1, acc + LAT);
        @(negedge clk);
        start = 1'b0;
        chk("busy_clr_after_start", {busy, cnt_clr}, 2'b11);
        wait_done();
        repeat (2) @(negedge clk);

        // Start pulsed during pair 1 must be ignored
        start = 1'b1;
        acc   = cyc + 1;
        push(4'b1001, 3'd1, acc + LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("idle_hold", {key, tie_cnt, key_valid, busy}, {4'b1001, 3'd1, 2'b10});

        // Reset during RUN of pair 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        chk("pre_reset_run", {ro_en, ro_sel}, {1'b1, 2'd2});
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset",
            {busy, done, ro_en, cnt_clr, key_valid, key, tie_cnt, ro_sel}, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);

        // All ties, start held for back-to-back runs
        for (int i = 0; i < NP; i++) begin
            ta[i] = 16'h1234;
            tb[i] = 16'h1234;
        end
        start = 1'b1;
        acc   = cyc + 1;
        push(4'b0000, 3'd4, acc + LAT);
        push(4'b0000, 3'd4, acc + LAT + 1 + LAT);
        wait_done();
        @(negedge clk);
        @(negedge clk);
        chk("b2b_restart", {cnt_clr, key_valid, busy}, 3'b101);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
